// File: rtl/video_timing_pkg.sv
// Shared timing constants, count type and set/clear flag helper for the raster generator.
package video_timing_pkg;

    typedef logic [8:0] cnt9_t;

    localparam cnt9_t VT_H_START   = 9'h080;
    localparam cnt9_t VT_V_START   = 9'h0F8;
    localparam cnt9_t VT_HBL_START = 9'h188;
    localparam cnt9_t VT_HBL_END   = 9'h088;
    localparam cnt9_t VT_HS_START  = 9'h1A0;
    localparam cnt9_t VT_HS_END    = 9'h1C0;
    localparam cnt9_t VT_VBL_START = 9'h1F0;
    localparam cnt9_t VT_VBL_END   = 9'h110;
    localparam cnt9_t VT_VS_START  = 9'h1F8;
    localparam cnt9_t VT_VS_END    = 9'h100;

    localparam int VT_H_TOTAL = 384;
    localparam int VT_V_TOTAL = 264;

    // Next state of an active-high set/clear flag; clear takes priority on a tie.
    function automatic logic sr_next(input logic cur, input cnt9_t nxt,
                                     input cnt9_t s, input cnt9_t e);
        if (nxt == e) return 1'b0;
        if (nxt == s) return 1'b1;
        return cur;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster bus between the timing generator (master) and the tile/sprite/palette stages.
// With VIDEO_FLIP_EN defined the bus also carries FLIP and the flipped counts HF/VF.
interface video_timing_if;
    import video_timing_pkg::*;

    logic  CEN;
    cnt9_t H;
    cnt9_t V;
    logic  HBL;
    logic  VBL;
    logic  HS_n;
    logic  VS_n;
    logic  LINE_END;
    logic  FRAME_END;
`ifdef VIDEO_FLIP_EN
    logic  FLIP;
    cnt9_t HF;
    cnt9_t VF;

    modport master (input CEN, FLIP,
                    output H, V, HBL, VBL, HS_n, VS_n, LINE_END, FRAME_END, HF, VF);
    modport slave  (output CEN, FLIP,
                    input H, V, HBL, VBL, HS_n, VS_n, LINE_END, FRAME_END, HF, VF);
`else
    modport master (input CEN,
                    output H, V, HBL, VBL, HS_n, VS_n, LINE_END, FRAME_END);
    modport slave  (output CEN,
                    input H, V, HBL, VBL, HS_n, VS_n, LINE_END, FRAME_END);
`endif
endinterface

// File: rtl/vt_counter9.sv
// 9-bit loadable up-counter: reloads load_val after all-ones, rco is the enabled ripple carry.
module vt_counter9
    import video_timing_pkg::*;
#(
    parameter cnt9_t RST_VAL = '0
) (
    input  logic  Clk,
    input  logic  Clear_bar,
    input  logic  en,
    input  cnt9_t load_val,
    output cnt9_t q,
    output cnt9_t q_nxt,
    output logic  rco
);

    assign q_nxt = (&q) ? load_val : q + 9'd1;
    assign rco   = (&q) & en;

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) q <= RST_VAL;
        else if (en)    q <= q_nxt;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: cascaded H/V counters plus registered blank/sync flags and strobes.
// Optional feature macro: VIDEO_FLIP_EN (frame-synchronous screen flip outputs HF/VF).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter cnt9_t H_START   = VT_H_START,
    parameter cnt9_t V_START   = VT_V_START,
    parameter cnt9_t HBL_START = VT_HBL_START,
    parameter cnt9_t HBL_END   = VT_HBL_END,
    parameter cnt9_t HS_START  = VT_HS_START,
    parameter cnt9_t HS_END    = VT_HS_END,
    parameter cnt9_t VBL_START = VT_VBL_START,
    parameter cnt9_t VBL_END   = VT_VBL_END,
    parameter cnt9_t VS_START  = VT_VS_START,
    parameter cnt9_t VS_END    = VT_VS_END
) (
    input  logic           Clk,
    input  logic           Clear_bar,
    video_timing_if.master vt
);

    cnt9_t h_q, h_nxt, v_q, v_nxt;
    logic  h_rco, v_rco;
    logic  hbl, hs, vbl, vs;

    vt_counter9 #(.RST_VAL(H_START)) u_hcnt (
        .Clk      (Clk),
        .Clear_bar(Clear_bar),
        .en       (vt.CEN),
        .load_val (H_START),
        .q        (h_q),
        .q_nxt    (h_nxt),
        .rco      (h_rco)
    );

    // V is clocked by H's ripple carry, exactly like the cascaded board counters.
    vt_counter9 #(.RST_VAL(V_START)) u_vcnt (
        .Clk      (Clk),
        .Clear_bar(Clear_bar),
        .en       (h_rco),
        .load_val (V_START),
        .q        (v_q),
        .q_nxt    (v_nxt),
        .rco      (v_rco)
    );

    // Flags decode the next count so they switch on the same edge as H/V.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            hbl <= 1'b1;
            hs  <= 1'b0;
            vbl <= 1'b1;
            vs  <= 1'b0;
        end else if (vt.CEN) begin
            hbl <= sr_next(hbl, h_nxt, HBL_START, HBL_END);
            hs  <= sr_next(hs,  h_nxt, HS_START,  HS_END);
            if (h_rco) begin
                vbl <= sr_next(vbl, v_nxt, VBL_START, VBL_END);
                vs  <= sr_next(vs,  v_nxt, VS_START,  VS_END);
            end
        end
    end

    assign vt.H         = h_q;
    assign vt.V         = v_q;
    assign vt.HBL       = hbl;
    assign vt.VBL       = vbl;
    assign vt.HS_n      = ~hs;
    assign vt.VS_n      = ~vs;
    assign vt.LINE_END  = h_rco & Clear_bar;
    assign vt.FRAME_END = v_rco & Clear_bar;

`ifdef VIDEO_FLIP_EN
    logic flip_q;

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) flip_q <= 1'b0;
        else if (v_rco) flip_q <= vt.FLIP;
    end

    assign vt.HF = {h_q[8], h_q[7:0] ^ {8{flip_q}}};
    assign vt.VF = {v_q[8], v_q[7:0] ^ {8{flip_q}}};
`endif

endmodule
